xbar_config_loader: RTL and testbench
=====================================

XBAR_CONFIG_LOADER -- requirements
Module: xbar_config_loader

Interface
REQ-001 Parameter NUM_IN, 31, crossbar input count; a legal select value is 0..NUM_IN-1.
REQ-002 Parameter NUM_OUT, 40, crossbar output count.
REQ-003 Parameter SEL_W, 5, select field width per output; total config width CFG_W = NUM_OUT*SEL_W = 200.
REQ-004 Parameter WORD_W, 8, config word width; NWORDS = CFG_W/WORD_W = 25; CFG_W SHALL be a multiple of WORD_W.
REQ-005 clk  input  1  sole clock; all state rising-edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 io_cfg_start  input  1  begin a new load sequence.
REQ-008 io_cfg_valid  input  1  io_cfg_data is valid.
REQ-009 io_cfg_data  input  WORD_W  config word.
REQ-010 io_cfg_ready  output  1  block accepts a word this cycle.
REQ-011 io_mux_configs  output  CFG_W  active select fields to the crossbar; field k occupies bits [k*SEL_W+SEL_W-1 : k*SEL_W].
REQ-012 io_busy  output  1  high in LOAD or CHECK.
REQ-013 io_done  output  1  one-cycle pulse on successful commit.
REQ-014 io_error  output  1  sticky, set when a loaded image is rejected.
REQ-015 io_word_count  output  5  words accepted in the current load.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, CHECK, and COMMIT.
REQ-017 From IDLE, io_cfg_start=1 SHALL enter LOAD next cycle, clear io_word_count to 0, clear io_error, and clear the shadow register.
REQ-018 io_cfg_ready SHALL be 1 only in LOAD; a word is accepted on a cycle where io_cfg_valid && io_cfg_ready.
REQ-019 On each accept, shadow <= {io_cfg_data, shadow[CFG_W-1:WORD_W]} and io_word_count SHALL increment, so the first word ends in bits [7:0] and the last in [199:192].
REQ-020 The accept making io_word_count reach NWORDS SHALL move the block to CHECK next cycle, with io_cfg_ready=0 in CHECK.
REQ-021 In CHECK (one cycle), each of NUM_OUT shadow fields SHALL be compared against NUM_IN; any field >= NUM_IN (i.e. value 31) SHALL make the image illegal.
REQ-022 A legal image SHALL go to COMMIT, where io_mux_configs <= shadow at the end of the COMMIT cycle and io_done=1 for exactly the following cycle, in which the state returns to IDLE.
REQ-023 An illegal image SHALL go to IDLE, set io_error=1, and leave io_mux_configs unchanged; io_done stays 0.
REQ-024 io_mux_configs SHALL change only on commit or reset, never during LOAD or CHECK (glitch-free crossbar configuration).
REQ-025 io_cfg_start=1 during LOAD SHALL restart the load (count=0, shadow cleared, io_error cleared), and any word presented that same cycle SHALL be discarded.
REQ-026 io_cfg_start SHALL be ignored in CHECK and COMMIT.
REQ-027 io_cfg_valid with io_cfg_ready=0 SHALL have no effect; valid gaps during LOAD SHALL stall without timeout.
REQ-028 io_busy SHALL be 1 exactly in LOAD and CHECK states.
REQ-029 Best-case latency from the first accept to the io_done pulse SHALL be NWORDS+2 cycles (25 accepts, CHECK, COMMIT, then the done cycle).

Reset
REQ-030 On reset assertion, the following SHALL happen immediately regardless of clk: state=IDLE, io_mux_configs=0 (all outputs select input 0), shadow=0, io_word_count=0, io_cfg_ready=0, io_busy=0, io_done=0, io_error=0.
REQ-031 Reset mid-LOAD or mid-CHECK SHALL discard the partial image, and no commit SHALL follow reset deassertion.

Verification
REQ-032 Start, then 25 back-to-back words 0x00..0x18 with a legal image -> io_done pulses once 27 cycles after the first accept; io_mux_configs equals the shifted concatenation; io_error=0.
REQ-033 Load an image with field 39 = 31 (word 24 = 0xF8) -> io_error=1, io_done=0, io_mux_configs retains the prior value.
REQ-034 Start, 10 words, start again, then 25 words all 0x00 -> io_mux_configs=0, io_word_count peaks at 25, and the first 10 words have no effect.
REQ-035 Random valid gaps during LOAD -> same committed value as the back-to-back case; ready stays high throughout LOAD.
REQ-036 Assert reset asynchronously after 12 accepts -> all outputs 0 immediately; a subsequent idle period produces no io_done.
REQ-037 io_cfg_start pulsed during CHECK -> ignored; commit completes normally.

Source files
------------

// File: rtl/xbar_config_loader.sv
// -----------------------------------------------------------------------------
// xbar_config_loader
//
// Loads a crossbar select image one word at a time into a shadow register.
// The full image is range-checked, then copied to the live crossbar
// configuration in one step. The live configuration is never disturbed
// while a load is in progress.
//
// Ports
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high
//   io_cfg_start    begin (or restart) a load sequence
//   io_cfg_valid    io_cfg_data carries a word
//   io_cfg_data     config word (WORD_W bits)
//   io_cfg_ready    block accepts a word this cycle (LOAD only)
//   io_mux_configs  live select fields; field k = bits [k*SEL_W +: SEL_W]
//   io_busy         high in LOAD and CHECK
//   io_done         one-cycle pulse after a successful commit
//   io_error        sticky; set when a loaded image is rejected
//   io_word_count   words accepted in the current load
//   dbg_state_o     current FSM state (0 IDLE, 1 LOAD, 2 CHECK, 3 COMMIT)
//
// Handshake: a word transfers on every rising edge where io_cfg_valid and
// io_cfg_ready are both high. io_cfg_ready depends only on the state, never
// on io_cfg_valid. A source may hold valid low for any number of cycles; the
// load simply stalls, and there is no timeout.
// -----------------------------------------------------------------------------
module xbar_config_loader #(
  parameter int NUM_IN  = 31,
  parameter int NUM_OUT = 40,
  parameter int SEL_W   = 5,
  parameter int WORD_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_cfg_start,
  input  logic                     io_cfg_valid,
  input  logic [WORD_W-1:0]        io_cfg_data,
  output logic                     io_cfg_ready,
  output logic [NUM_OUT*SEL_W-1:0] io_mux_configs,
  output logic                     io_busy,
  output logic                     io_done,
  output logic                     io_error,
  output logic [4:0]               io_word_count,
  output logic [1:0]               dbg_state_o
);

  localparam int CFG_W  = NUM_OUT * SEL_W;
  localparam int NWORDS = CFG_W / WORD_W;

  // The image must split evenly into words.
  if ((CFG_W % WORD_W) != 0) begin : g_bad_width
    $error("CFG_W must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic [4:0]         count_q, count_d;
  logic               error_q, error_d;
  logic               done_q, done_d;
  logic               illegal;

  // An image is illegal if any select field addresses a non-existent input.
  // The compare is widened so a NUM_IN equal to 2**SEL_W still works.
  always_comb begin
    illegal = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (32'(shadow_q[k*SEL_W +: SEL_W]) >= 32'(NUM_IN)) begin
        illegal = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    count_d  = count_q;
    error_d  = error_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (io_cfg_start) begin
          state_d  = S_LOAD;
          shadow_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end
      end

      S_LOAD: begin
        if (io_cfg_start) begin
          // Restart: any word offered this same cycle is dropped.
          shadow_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end else if (io_cfg_valid) begin
          // Shift in from the top so the first word lands in the low bits.
          shadow_d = {io_cfg_data, shadow_q[CFG_W-1:WORD_W]};
          count_d  = count_q + 5'd1;
          if (count_q == 5'(NWORDS - 1)) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (illegal) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        cfg_d   = shadow_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cfg_q    <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      count_q  <= count_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign io_cfg_ready   = (state_q == S_LOAD);
  assign io_busy        = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign io_mux_configs = cfg_q;
  assign io_done        = done_q;
  assign io_error       = error_q;
  assign io_word_count  = count_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_xbar_config_loader.sv
// -----------------------------------------------------------------------------
// tb_xbar_config_loader
//
// Self-checking bench for xbar_config_loader. The reference model keeps the
// words of a load in an array, builds the expected image by placing word i at
// bits [i*8 +: 8], and judges legality by scanning the 5-bit fields.
// -----------------------------------------------------------------------------
module tb_xbar_config_loader;

  localparam int NUM_IN  = 31;
  localparam int NUM_OUT = 40;
  localparam int SEL_W   = 5;
  localparam int WORD_W  = 8;
  localparam int CFG_W   = NUM_OUT * SEL_W;
  localparam int NWORDS  = CFG_W / WORD_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              valid = 1'b0;
  logic [WORD_W-1:0] data  = '0;
  logic              ready, busy, done, error;
  logic [CFG_W-1:0]  mux_cfg;
  logic [4:0]        word_count;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  xbar_config_loader #(
    .NUM_IN (NUM_IN),
    .NUM_OUT(NUM_OUT),
    .SEL_W  (SEL_W),
    .WORD_W (WORD_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_cfg_start  (start),
    .io_cfg_valid  (valid),
    .io_cfg_data   (data),
    .io_cfg_ready  (ready),
    .io_mux_configs(mux_cfg),
    .io_busy       (busy),
    .io_done       (done),
    .io_error      (error),
    .io_word_count (word_count),
    .dbg_state_o   (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int               n_tests  = 0;
  int               n_fail   = 0;
  int               done_cnt = 0;
  logic [CFG_W-1:0] exp_cfg  = '0;
  logic [WORD_W-1:0] words [NWORDS];
  int               t_first, t_last;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference image: word i occupies bits [i*WORD_W +: WORD_W].
  function automatic logic [CFG_W-1:0] image_of();
    logic [CFG_W-1:0] img;
    img = '0;
    for (int i = 0; i < NWORDS; i++) img[i*WORD_W +: WORD_W] = words[i];
    return img;
  endfunction

  function automatic bit legal(input logic [CFG_W-1:0] img);
    for (int k = 0; k < NUM_OUT; k++) begin
      if (int'(img[k*SEL_W +: SEL_W]) >= NUM_IN) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Live config must never move while a load or check is in flight.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) chk("cfg_hold", mux_cfg, exp_cfg);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input bit with_word);
    @(negedge clk);
    start = 1'b1;
    valid = with_word;
    data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    chk("start_count", word_count, 0);
    chk("start_err", error, 0);
    chk("start_ready", ready, 1);
  endtask

  task automatic load_words(input int n, input int max_gap, input bit start_in_check);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        @(negedge clk);
        valid = 1'b0;
        chk("ready_gap", ready, 1);
      end
      @(negedge clk);
      chk("ready_acc", ready, 1);
      valid = 1'b1;
      data  = words[i];
      if (i == 0) t_first = cyc;
      t_last = cyc;
    end
    @(negedge clk);
    valid = 1'b0;
    start = start_in_check;
    if (n == NWORDS) begin
      chk("check_ready", ready, 0);
      chk("check_busy", busy, 1);
    end else begin
      chk("count_part", word_count, n);
    end
    if (start_in_check) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_load(input bit exp_ok, input bit check_lat);
    int d0;
    bit seen;
    logic [CFG_W-1:0] img;
    d0   = done_cnt;
    seen = 1'b0;
    img  = image_of();
    if (exp_ok) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("done_seen", seen, 1);
      if (seen) begin
        chk("done_lat", cyc - t_last, 3);
        if (check_lat) chk("done_lat27", cyc - t_first, 27);
      end
      chk("cfg_commit", mux_cfg, img);
      chk("err_ok", error, 0);
      chk("count_end", word_count, NWORDS);
      exp_cfg = img;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("done_once", done_cnt - d0, 1);
    end else begin
      repeat (6) @(negedge clk);
      chk("err_set", error, 1);
      chk("no_done", done_cnt - d0, 0);
      chk("cfg_keep", mux_cfg, exp_cfg);
      chk("bad_busy", busy, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_cfg", mux_cfg, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_count", word_count, 0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back ascending words, latency measured from first accept.
    for (int i = 0; i < NWORDS; i++) words[i] = 8'(i);
    drive_start(1'b0);
    load_words(NWORDS, 0, 1'b0);
    finish_load(legal(image_of()), 1'b1);

    // Last word 0xF8 puts 31 into field 39: rejected, prior config kept.
    for (int i = 0; i < NWORDS - 1; i++) words[i] = 8'($urandom_range(0, 15));
    words[NWORDS-1] = 8'hF8;
    drive_start(1'b0);
    load_words(NWORDS, 0, 1'b0);
    finish_load(1'b0, 1'b0);

    // Partial load, restart with a word offered on the restart cycle, then zeros.
    for (int i = 0; i < NWORDS; i++) words[i] = 8'($urandom_range(1, 255));
    drive_start(1'b0);
    load_words(10, 2, 1'b0);
    drive_start(1'b1);
    for (int i = 0; i < NWORDS; i++) words[i] = '0;
    load_words(NWORDS, 0, 1'b0);
    finish_load(1'b1, 1'b0);

    // Ascending words again, with random valid gaps.
    for (int i = 0; i < NWORDS; i++) words[i] = 8'(i);
    drive_start(1'b0);
    load_words(NWORDS, 3, 1'b0);
    finish_load(legal(image_of()), 1'b0);

    // Random images; the model decides legality.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NWORDS; i++) begin
        words[i] = (r % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      end
      drive_start(1'b0);
      load_words(NWORDS, r % 3, 1'b0);
      finish_load(legal(image_of()), 1'b0);
    end

    // Asynchronous reset after 12 accepts.
    for (int i = 0; i < NWORDS; i++) words[i] = 8'($urandom_range(0, 15));
    drive_start(1'b0);
    load_words(12, 0, 1'b0);
    #3 reset = 1'b1;
    exp_cfg = '0;
    #1;
    chk("arst_cfg", mux_cfg, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", error, 0);
    chk("arst_count", word_count, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      chk("arst_no_done", done_cnt - d0, 0);
      chk("arst_cfg_idle", mux_cfg, 0);
      chk("arst_busy_idle", busy, 0);
    end

    // Start pulsed during CHECK is ignored; commit completes with count intact.
    for (int i = 0; i < NWORDS; i++) words[i] = 8'($urandom_range(0, 15));
    drive_start(1'b0);
    load_words(NWORDS, 0, 1'b1);
    finish_load(legal(image_of()), 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
